twobitcompare: RTL and testbench
================================

TWOBITCOMPARE -- requirements
Module: twobitcompare

Interface
REQ-001 Parameter: CNT_W, default 8, width of each statistics counter; used only when TWOBITCOMPARE_STATS_EN is defined.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: A1  input  1  operand A, MSB.
REQ-006 Port: A2  input  1  operand A, LSB.
REQ-007 Port: B1  input  1  operand B, MSB.
REQ-008 Port: B2  input  1  operand B, LSB.
REQ-009 Port: in_valid  input  1  sample operands this cycle.
REQ-010 Port: F1  output  1  registered flag, A > B.
REQ-011 Port: F2  output  1  registered flag, A == B.
REQ-012 Port: F3  output  1  registered flag, A < B.
REQ-013 Port: out_valid  output  1  one-cycle pulse; F1..F3 updated this cycle.
REQ-014 Ports (macro only): gt_cnt, eq_cnt, lt_cnt  output  CNT_W each  result counts.

Function
REQ-015 Operands SHALL be unsigned: A = {A1,A2}, B = {B1,B2}, range 0..3.
REQ-016 On a rising edge with in_valid=1 and reset=0, the block SHALL load F1=(A>B), F2=(A==B), F3=(A<B).
REQ-017 Latency SHALL be exactly one cycle; out_valid SHALL equal in_valid delayed by one cycle.
REQ-018 When in_valid=0, F1..F3 SHALL hold their last value; out_valid SHALL be 0.
REQ-019 After the first valid sample, exactly one of F1, F2, F3 SHALL be 1 (one-hot).
REQ-020 Back-to-back in_valid SHALL produce one result per cycle with no stall and no bubble.
REQ-021 Operands SHALL be sampled only at clock edges; changes between edges SHALL have no effect.

Reset
REQ-022 With reset=1 at a rising edge: F1=0, F2=0, F3=0, out_valid=0, and all counters=0.
REQ-023 Reset SHALL take priority over in_valid in the same cycle; that sample SHALL be discarded.
REQ-024 Reset asserted mid-stream SHALL cancel the pending out_valid.

Configuration
REQ-025 Macro TWOBITCOMPARE_STATS_EN defined: gt_cnt, eq_cnt and lt_cnt SHALL exist.
REQ-026 With the macro, each valid sample SHALL increment the matching counter by 1 in the same edge that loads F1..F3.
REQ-027 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-028 Macro undefined: the counter ports and counter logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-029 Shared package twobitcompare_pkg SHALL hold the 2-bit operand typedef, the 3-bit result typedef {gt,eq,lt}, and the constants RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001.
REQ-030 Sub-module cmp2_core SHALL be purely combinational, mapping {A1,A2},{B1,B2} to the 3-bit result.
REQ-031 twobitcompare SHALL contain the registers, the valid pipeline and the optional counters.

Verification
REQ-032 Reset held for 2 cycles -> F1..F3=000, out_valid=0, counters=0.
REQ-033 Exhaustive sweep of all 16 operand combinations, one per cycle with in_valid=1 -> one cycle later: A=2,B=1 gives 100; A=3,B=3 gives 010; A=0,B=2 gives 001; 6 GT, 4 EQ and 6 LT in total.
REQ-034 A=3,B=0 with in_valid=1, then in_valid=0 while operands change to A=0,B=3 -> F stays 100, out_valid pulses once.
REQ-035 reset and in_valid asserted together with A=1,B=0 -> F=000 next cycle, no out_valid.
REQ-036 STATS_EN, CNT_W=2, A=B held valid 5 cycles -> eq_cnt saturates at 3, gt_cnt=lt_cnt=0.

Source files
------------

// File: rtl/twobitcompare_pkg.sv
// Shared types and result encodings for the 2-bit magnitude comparator.
package twobitcompare_pkg;

  typedef logic [1:0] operand_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } result_t;

  localparam result_t RES_GT = 3'b100;
  localparam result_t RES_EQ = 3'b010;
  localparam result_t RES_LT = 3'b001;
  localparam result_t RES_NONE = 3'b000;

endpackage

// File: rtl/cmp2_core.sv
// Combinational 2-bit unsigned compare producing a one-hot {gt,eq,lt} result.
module cmp2_core
  import twobitcompare_pkg::*;
(
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [2:0] o_res
);

  operand_t w_a;
  operand_t w_b;
  result_t  w_res;

  assign w_a = i_a;
  assign w_b = i_b;

  always_comb begin
    // NOTE: default first, so every path assigns w_res and no latch is inferred.
    w_res = RES_EQ;
    if (w_a > w_b) begin
      w_res = RES_GT;
    end else if (w_a < w_b) begin
      w_res = RES_LT;
    end
  end

  assign o_res = w_res;

endmodule

// File: rtl/twobitcompare.sv
// Registered 2-bit comparator with a one-cycle valid pipeline.
// Optional saturating result counters when TWOBITCOMPARE_STATS_EN is defined.
module twobitcompare
  import twobitcompare_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic A1,
  input  logic A2,
  input  logic B1,
  input  logic B2,
  input  logic in_valid,
  output logic F1,
  output logic F2,
  output logic F3,
  output logic out_valid
`ifdef TWOBITCOMPARE_STATS_EN
  ,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
`endif
);

  result_t w_res;
  result_t r_res;
  logic    r_valid;

  cmp2_core u_core (
    .i_a   ({A1, A2}),
    .i_b   ({B1, B2}),
    .o_res (w_res)
  );

  // Flags hold their last value while in_valid is low; reset wins over a sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_res   <= RES_NONE;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_res <= w_res;
      end
    end
  end

  assign F1        = r_res.gt;
  assign F2        = r_res.eq;
  assign F3        = r_res.lt;
  assign out_valid = r_valid;

`ifdef TWOBITCOMPARE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_gt_cnt;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_lt_cnt;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gt_cnt <= '0;
      r_eq_cnt <= '0;
      r_lt_cnt <= '0;
    end else if (in_valid) begin
      if (w_res.gt && (r_gt_cnt != CNT_MAX)) r_gt_cnt <= r_gt_cnt + CNT_W'(1);
      if (w_res.eq && (r_eq_cnt != CNT_MAX)) r_eq_cnt <= r_eq_cnt + CNT_W'(1);
      if (w_res.lt && (r_lt_cnt != CNT_MAX)) r_lt_cnt <= r_lt_cnt + CNT_W'(1);
    end
  end

  assign gt_cnt = r_gt_cnt;
  assign eq_cnt = r_eq_cnt;
  assign lt_cnt = r_lt_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt_w;
  assign w_unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_twobitcompare.sv
// Self-checking bench for twobitcompare: directed cases plus randomized traffic
// against an arithmetic reference model.
module tb_twobitcompare;

`ifdef TWOBITCOMPARE_STATS_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 8;
`endif

  logic clk;
  logic reset;
  logic A1, A2, B1, B2;
  logic in_valid;
  logic F1, F2, F3;
  logic out_valid;
`ifdef TWOBITCOMPARE_STATS_EN
  logic [TB_CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [2:0] m_f;
  logic       m_v;
  int         m_cnt [3];
  int         cnt_max;

  twobitcompare #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .B1        (B1),
    .B2        (B2),
    .in_valid  (in_valid),
    .F1        (F1),
    .F2        (F2),
    .F3        (F3),
    .out_valid (out_valid)
`ifdef TWOBITCOMPARE_STATS_EN
    ,
    .gt_cnt    (gt_cnt),
    .eq_cnt    (eq_cnt),
    .lt_cnt    (lt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int a, input int b, input logic v, input logic rst);
    logic [1:0] av, bv;
    av = a[1:0];
    bv = b[1:0];
    A1 = av[1]; A2 = av[0];
    B1 = bv[1]; B2 = bv[0];
    in_valid = v;
    reset = rst;
  endtask

  // Advance the model from the inputs currently applied, then cross one rising edge.
  task automatic tick();
    int a, b;
    a = int'({A1, A2});
    b = int'({B1, B2});
    if (reset) begin
      m_f = 3'b000;
      m_v = 1'b0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else begin
      m_v = in_valid;
      if (in_valid) begin
        m_f = {a > b, a == b, a < b};
        if (a > b && m_cnt[0] < cnt_max) m_cnt[0]++;
        if (a == b && m_cnt[1] < cnt_max) m_cnt[1]++;
        if (a < b && m_cnt[2] < cnt_max) m_cnt[2]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".F"}, 32'({F1, F2, F3}), 32'(m_f));
    check({tag, ".ov"}, 32'(out_valid), 32'(m_v));
`ifdef TWOBITCOMPARE_STATS_EN
    check({tag, ".gt_cnt"}, 32'(gt_cnt), 32'(m_cnt[0]));
    check({tag, ".eq_cnt"}, 32'(eq_cnt), 32'(m_cnt[1]));
    check({tag, ".lt_cnt"}, 32'(lt_cnt), 32'(m_cnt[2]));
`endif
  endtask

  initial begin
    int n_gt, n_eq, n_lt;
    cnt_max = (1 << TB_CNT_W) - 1;
    m_f = 3'b000;
    m_v = 1'b0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    drive(0, 0, 1'b0, 1'b1);

    // Reset held two cycles
    tick();
    tick();
    check("reset.F", 32'({F1, F2, F3}), 32'h0);
    check("reset.ov", 32'(out_valid), 32'h0);
    check_outputs("reset");

    // Exhaustive sweep, back-to-back
    n_gt = 0; n_eq = 0; n_lt = 0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        drive(a, b, 1'b1, 1'b0);
        tick();
        check_outputs($sformatf("sweep_a%0d_b%0d", a, b));
        if (F1) n_gt++;
        if (F2) n_eq++;
        if (F3) n_lt++;
        if (a == 2 && b == 1) check("sweep_2_1", 32'({F1, F2, F3}), 32'b100);
        if (a == 3 && b == 3) check("sweep_3_3", 32'({F1, F2, F3}), 32'b010);
        if (a == 0 && b == 2) check("sweep_0_2", 32'({F1, F2, F3}), 32'b001);
      end
    end
    check("sweep_n_gt", 32'(n_gt), 32'd6);
    check("sweep_n_eq", 32'(n_eq), 32'd4);
    check("sweep_n_lt", 32'(n_lt), 32'd6);

    // Hold while idle, operands changing
    drive(3, 0, 1'b1, 1'b0);
    tick();
    check("hold_load.F", 32'({F1, F2, F3}), 32'b100);
    check("hold_load.ov", 32'(out_valid), 32'd1);
    drive(0, 3, 1'b0, 1'b0);
    tick();
    check("hold1.F", 32'({F1, F2, F3}), 32'b100);
    check("hold1.ov", 32'(out_valid), 32'd0);
    drive(1, 2, 1'b0, 1'b0);
    tick();
    check_outputs("hold2");

    // Reset beats a simultaneous valid sample
    drive(1, 0, 1'b1, 1'b1);
    tick();
    check("rst_prio.F", 32'({F1, F2, F3}), 32'b000);
    check("rst_prio.ov", 32'(out_valid), 32'd0);
    drive(1, 0, 1'b0, 1'b0);
    tick();
    check_outputs("rst_prio_after");

    // Reset mid-stream cancels the pulse
    drive(2, 3, 1'b1, 1'b0);
    tick();
    check_outputs("mid_pre");
    drive(3, 2, 1'b1, 1'b1);
    tick();
    check("mid_rst.ov", 32'(out_valid), 32'd0);
    check_outputs("mid_rst");

`ifdef TWOBITCOMPARE_STATS_EN
    // Equal operands saturate eq_cnt
    drive(2, 2, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(2, 2, 1'b1, 1'b0);
      tick();
    end
    check("sat.eq_cnt", 32'(eq_cnt), 32'd3);
    check("sat.gt_cnt", 32'(gt_cnt), 32'd0);
    check("sat.lt_cnt", 32'(lt_cnt), 32'd0);
`endif

    // Random traffic with glitching operands between edges
    for (int i = 0; i < 300; i++) begin
      drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'b0);
      #2;
      drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      tick();
      check_outputs($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
